// File: rtl/saturate_pack_if.sv
// saturate_pack_if: handshake, data and saturation-status signals of the 32-to-16 narrowing packer
interface saturate_pack_if #(
    parameter int SAT_CNT_W = 8
);
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [31:0]          in_data_i;
    logic                 keep_sign_i;
    logic                 flush_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [31:0]          out_data_o;
    logic                 sat_o;
    logic                 clr_sat_i;
    logic [SAT_CNT_W-1:0] sat_count_o;

    modport master (
        output in_valid_i, in_data_i, keep_sign_i, flush_i, out_ready_i, clr_sat_i,
        input  in_ready_o, out_valid_o, out_data_o, sat_o, sat_count_o
    );

    modport slave (
        input  in_valid_i, in_data_i, keep_sign_i, flush_i, out_ready_i, clr_sat_i,
        output in_ready_o, out_valid_o, out_data_o, sat_o, sat_count_o
    );
endinterface

// File: rtl/saturate_pack.sv
// saturate_pack: narrows 32-bit beats to 16 bits with saturation and packs pairs into 32-bit words
module saturate_pack #(
    parameter int SAT_CNT_W = 8
) (
    input logic           clk_i,
    input logic           rst_i,
    saturate_pack_if.slave bus
);
    typedef enum logic {EMPTY, HALF} state_t;

    state_t               r_state;
    logic [15:0]          r_low;
    logic [31:0]          r_out;
    logic                 r_ov;
    logic                 r_sat;
    logic [SAT_CNT_W-1:0] r_cnt;

    logic                 w_sign_fit;
    logic                 w_uns_fit;
    logic                 w_sat;
    logic [15:0]          w_res;
    logic                 w_free;
    logic                 w_ready;
    logic                 w_acc;
    logic                 w_load;
    logic [31:0]          w_word;

    // Narrowing, handshake and word-load decisions for the current cycle
    always_comb begin
        w_sign_fit = (&bus.in_data_i[31:15]) | ~(|bus.in_data_i[31:15]);
        w_uns_fit  = ~(|bus.in_data_i[31:16]);
        w_sat      = bus.keep_sign_i ? ~w_sign_fit : ~w_uns_fit;
        w_res      = !w_sat ? bus.in_data_i[15:0] :
                     !bus.keep_sign_i ? 16'hFFFF :
                     bus.in_data_i[31] ? 16'h8000 : 16'h7FFF;
        w_free     = ~r_ov | bus.out_ready_i;
        w_ready    = ~rst_i & ((r_state == EMPTY) | w_free);
        w_acc      = bus.in_valid_i & w_ready;
        w_load     = (r_state == HALF) & (w_acc | (bus.flush_i & w_free));
        w_word     = w_acc ? {w_res, r_low} : {16'h0000, r_low};
    end

    assign bus.in_ready_o  = w_ready;
    assign bus.out_valid_o = r_ov;
    assign bus.out_data_o  = r_out;
    assign bus.sat_o       = r_sat;
    assign bus.sat_count_o = r_cnt;

    // Pairing FSM: hold the low half, then complete or flush into the output register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= EMPTY;
            r_low   <= '0;
            r_out   <= '0;
            r_ov    <= 1'b0;
        end else begin
            if (w_load) begin
                r_state <= EMPTY;
                r_out   <= w_word;
            end else if (r_state == EMPTY && w_acc) begin
                r_state <= HALF;
                r_low   <= w_res;
            end
            r_ov <= w_load | (r_ov & ~bus.out_ready_i);
        end
    end

    // Sticky saturation flag and non-wrapping event counter; a same-cycle event survives a clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sat <= 1'b0;
            r_cnt <= '0;
        end else if (bus.clr_sat_i) begin
            r_sat <= w_acc & w_sat;
            r_cnt <= (w_acc & w_sat) ? SAT_CNT_W'(1) : '0;
        end else if (w_acc & w_sat) begin
            r_sat <= 1'b1;
            r_cnt <= (&r_cnt) ? r_cnt : r_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_saturate_pack.sv
// tb_saturate_pack: directed and randomized checks of saturate_pack against a queue-based reference model
module tb_saturate_pack;
    localparam int SAT_CNT_W = 8;
    localparam int CNT_MAX   = (1 << SAT_CNT_W) - 1;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   checks = 0;
    int   failures = 0;

    saturate_pack_if #(.SAT_CNT_W(SAT_CNT_W)) bus ();
    saturate_pack #(.SAT_CNT_W(SAT_CNT_W)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

    always #5 clk_i = ~clk_i;

    logic [15:0] m_pend[$];
    logic        m_ov;
    logic [31:0] m_od;
    logic        m_sat;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend.delete();
        m_ov  = 1'b0;
        m_od  = '0;
        m_sat = 1'b0;
        m_cnt = 0;
    endtask

    task automatic narrow(input logic [31:0] d, input logic ks, output logic [15:0] r, output logic s);
        int sv;
        sv = $signed(d);
        s  = 1'b0;
        r  = d[15:0];
        if (ks) begin
            if (sv > 32767) begin r = 16'h7FFF; s = 1'b1; end
            else if (sv < -32768) begin r = 16'h8000; s = 1'b1; end
        end else if (d > 32'h0000FFFF) begin
            r = 16'hFFFF; s = 1'b1;
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic ks,
                        input logic fl, input logic ordy, input logic clr);
        logic        exp_ready, acc, free, load, s;
        logic [15:0] r;
        logic [31:0] w;
        bus.in_valid_i  = v;
        bus.in_data_i   = d;
        bus.keep_sign_i = ks;
        bus.flush_i     = fl;
        bus.out_ready_i = ordy;
        bus.clr_sat_i   = clr;
        @(negedge clk_i);
        free      = !m_ov || ordy;
        exp_ready = (m_pend.size() == 0) || free;
        chk("in_ready", {31'b0, bus.in_ready_o}, {31'b0, exp_ready});
        chk("out_valid", {31'b0, bus.out_valid_o}, {31'b0, m_ov});
        chk("out_data", bus.out_data_o, m_od);
        chk("sat", {31'b0, bus.sat_o}, {31'b0, m_sat});
        chk("sat_count", 32'(bus.sat_count_o), 32'(m_cnt));
        narrow(d, ks, r, s);
        acc  = v && exp_ready;
        load = 1'b0;
        w    = '0;
        if (acc) begin
            if (m_pend.size() == 0) m_pend.push_back(r);
            else begin w = {r, m_pend.pop_front()}; load = 1'b1; end
        end else if (fl && m_pend.size() == 1 && free) begin
            w = {16'h0000, m_pend.pop_front()};
            load = 1'b1;
        end
        m_ov = load ? 1'b1 : (ordy ? 1'b0 : m_ov);
        if (load) m_od = w;
        if (clr) begin
            m_sat = acc && s;
            m_cnt = (acc && s) ? 1 : 0;
        end else if (acc && s) begin
            m_sat = 1'b1;
            m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_reset();
        rst_i = 1'b1;
        #1;
        chk("rst_out_valid", {31'b0, bus.out_valid_o}, 32'h0);
        chk("rst_out_data", bus.out_data_o, 32'h0);
        chk("rst_sat", {31'b0, bus.sat_o}, 32'h0);
        chk("rst_sat_count", 32'(bus.sat_count_o), 32'h0);
        chk("rst_in_ready", {31'b0, bus.in_ready_o}, 32'h0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        model_reset();
    endtask

    function automatic logic [31:0] rand_data();
        logic [31:0] b[6];
        b = '{32'h00007FFF, 32'h00008000, 32'hFFFF8000, 32'hFFFF7FFF, 32'h0000FFFF, 32'h00010000};
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 65535));
            1: return 32'h0 - 32'($urandom_range(0, 40000));
            2: return b[$urandom_range(0, 5)];
            default: return $urandom();
        endcase
    endfunction

    initial begin
        bus.in_valid_i = 0; bus.in_data_i = 0; bus.keep_sign_i = 0;
        bus.flush_i = 0; bus.out_ready_i = 0; bus.clr_sat_i = 0;
        model_reset();
        #2;
        pulse_reset();

        // signed pair, no saturation, one-cycle valid pulse
        step(1, 32'h00001234, 1, 0, 1, 0);
        step(1, 32'hFFFF8000, 1, 0, 1, 0);
        chk("d34_data", bus.out_data_o, 32'h80001234);
        chk("d34_valid", {31'b0, bus.out_valid_o}, 32'h1);
        chk("d34_sat", {31'b0, bus.sat_o}, 32'h0);
        step(0, 0, 1, 0, 1, 0);
        chk("d34_valid_drop", {31'b0, bus.out_valid_o}, 32'h0);

        // signed saturation both directions
        step(1, 32'h00010000, 1, 0, 1, 0);
        step(1, 32'hFFFE0000, 1, 0, 1, 0);
        chk("d35_data", bus.out_data_o, 32'h80007FFF);
        chk("d35_cnt", 32'(bus.sat_count_o), 32'd2);
        chk("d35_sat", {31'b0, bus.sat_o}, 32'h1);

        // unsigned saturation then flush; flush in EMPTY is ignored
        step(0, 0, 0, 1, 1, 1);
        step(1, 32'h00020005, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        chk("d36_data", bus.out_data_o, 32'h0000FFFF);
        chk("d36_cnt", 32'(bus.sat_count_o), 32'd1);
        step(0, 0, 0, 1, 1, 0);
        chk("d36_empty_flush", {31'b0, bus.out_valid_o}, 32'h0);

        // backpressure with four beats, then drain-and-load with no bubble
        step(1, 32'h00000011, 1, 0, 0, 0);
        step(1, 32'h00000022, 1, 0, 0, 0);
        step(1, 32'h00000033, 1, 0, 0, 0);
        chk("d37_ready_low", {31'b0, bus.in_ready_o}, 32'h0);
        step(1, 32'h00000044, 1, 0, 0, 0);
        chk("d37_hold", bus.out_data_o, 32'h00220011);
        step(1, 32'h00000044, 1, 1, 0, 0);
        chk("d37_hold_flush", bus.out_data_o, 32'h00220011);
        step(1, 32'h00000044, 1, 0, 1, 0);
        chk("d37_second", bus.out_data_o, 32'h00440033);
        chk("d37_no_bubble", {31'b0, bus.out_valid_o}, 32'h1);
        step(0, 0, 1, 0, 1, 0);

        // reset mid-operation discards the pending half
        step(1, 32'h00000055, 1, 0, 1, 0);
        pulse_reset();
        step(1, 32'h00000001, 1, 0, 1, 0);
        step(1, 32'h00000002, 1, 0, 1, 0);
        chk("d38_data", bus.out_data_o, 32'h00020001);

        // counter saturates at all-ones, then clear with a coincident saturated beat
        for (int i = 0; i < CNT_MAX + 6; i++) step(1, 32'h40000000, 1, 0, 1, 0);
        chk("d39_cnt_max", 32'(bus.sat_count_o), 32'(CNT_MAX));
        step(1, 32'h80000000, 1, 0, 1, 1);
        chk("d39_cnt_clr", 32'(bus.sat_count_o), 32'd1);
        chk("d39_sat_clr", {31'b0, bus.sat_o}, 32'h1);
        step(0, 0, 1, 0, 1, 1);
        chk("clr_only", 32'(bus.sat_count_o), 32'd0);

        // randomized traffic against the reference model
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 3) != 0, rand_data(), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 30) == 0);
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
